mux_rr_reg: RTL and testbench

Registered N-channel arbitrating multiplexer with valid/ready handshakes, the parametrised successor of the datapath 2:1 mux. It selects one of N requesting input channels, round-robin or fixed-priority, and loads the winner into a one-entry output register. It sits between multiple producers, such as pipeline write-back sources or memory request ports, and a single consumer. Throughput is one transfer per cycle.

---
 rtl/mux_rr_reg_if.sv | 27 ++
 rtl/mux_rr_reg.sv | 85 ++++++++
 tb/tb_mux_rr_reg.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/mux_rr_reg_if.sv
// Bundle of the N-channel request side and the single registered output side of mux_rr_reg.
// Pure wiring, no latency; the master drives requests and out_ready, the slave (the mux) drives grants and output.
// Backpressure: out_ready from the consumer, in_ready per channel back to the producers.
interface mux_rr_reg_if #(
    parameter int N     = 4,
    parameter int WIDTH = 32
);
    localparam int SELW = $clog2(N);

    logic [N-1:0]       in_valid;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic [SELW-1:0]    out_sel;
    logic               out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );
endinterface

// File: rtl/mux_rr_reg.sv
// N-channel arbitrating mux (round-robin or fixed priority) into a one-entry output register.
// Latency: one cycle from accepted input to out_valid/out_data; one transfer per cycle sustained.
// Backpressure: out_ready=0 with a full register drops every in_ready; drain and reload share an edge.
module mux_rr_reg #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int RR    = 1
) (
    input logic          clk,
    input logic          resetn,
    mux_rr_reg_if.slave  bus
);
    localparam int SELW = $clog2(N);

    logic               load_en;
    logic [N-1:0]       grant;
    logic [SELW-1:0]    gnt_idx;
    logic               found;
    logic [SELW:0]      sum;
    logic [SELW-1:0]    idx;
    logic [SELW-1:0]    start;
    logic [SELW-1:0]    rr_ptr;
    logic               out_valid_q;
    logic [WIDTH-1:0]   out_data_q;
    logic [SELW-1:0]    out_sel_q;
    logic [WIDTH-1:0]   ch_data [N];

    // Slice the flat input bus into one word per channel.
    for (genvar g = 0; g < N; g++) begin : g_slice
        assign ch_data[g] = bus.in_data[g*WIDTH +: WIDTH];
    end

    // The register can take a word when empty or when it is being drained this cycle.
    assign load_en = !out_valid_q || bus.out_ready;

    // Fixed priority is just a round-robin search that always starts at channel 0.
    assign start = (RR != 0) ? rr_ptr : '0;

    // Search channels start, start+1, ... modulo N; first requester wins.
    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        found   = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, start} + (SELW+1)'(k);
            if (sum >= (SELW+1)'(N)) begin
                sum = sum - (SELW+1)'(N);
            end
            idx = sum[SELW-1:0];
            if (!found && bus.in_valid[idx]) begin
                grant[idx] = 1'b1;
                gnt_idx    = idx;
                found      = 1'b1;
            end
        end
    end

    assign bus.in_ready  = grant & {N{load_en}};
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;

    // Output register and round-robin pointer; the pointer moves only on an accepted transfer.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            rr_ptr      <= '0;
        end else if (load_en) begin
            if (found) begin
                out_valid_q <= 1'b1;
                out_data_q  <= ch_data[gnt_idx];
                out_sel_q   <= gnt_idx;
                if (RR != 0) begin
                    rr_ptr <= (gnt_idx == SELW'(N-1)) ? '0 : gnt_idx + SELW'(1);
                end
            end else begin
                out_valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mux_rr_reg.sv
// Bench for mux_rr_reg: one round-robin and one fixed-priority instance fed identical stimulus.
// Directed table, hand sequences for async reset, then random traffic against a queue-free reference model.
// Outputs are sampled 1 time unit after the rising edge; inputs change 1 unit after the edge.
module tb_mux_rr_reg;
    localparam int N = 4;
    localparam int W = 32;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    mux_rr_reg_if #(.N(N), .WIDTH(W)) bus_rr ();
    mux_rr_reg_if #(.N(N), .WIDTH(W)) bus_fp ();

    mux_rr_reg #(.WIDTH(W), .N(N), .RR(1)) u_rr (.clk(clk), .resetn(resetn), .bus(bus_rr));
    mux_rr_reg #(.WIDTH(W), .N(N), .RR(0)) u_fp (.clk(clk), .resetn(resetn), .bus(bus_fp));

    int n_cmp = 0;
    int n_err = 0;

    // Reference state, index 0 = round-robin instance, 1 = fixed-priority instance.
    int           m_ptr [2];
    logic         m_vld [2];
    logic [31:0]  m_dat [2];
    int           m_sel [2];
    int           m_win [2];
    logic         m_ld  [2];
    logic [127:0] cur_d;

    typedef struct {
        logic [3:0] v;
        logic       ordy;
        logic [3:0] rdy_rr;
        logic [3:0] rdy_fp;
        logic       vld;
        int         sel_rr;
        int         sel_fp;
    } vec_t;

    vec_t tbl [$];

    function automatic int pick(input logic [3:0] v, input int first);
        for (int k = 0; k < N; k++) begin
            int c;
            c = (first + k) % N;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [3:0] onehot(input int w);
        logic [3:0] r;
        r = '0;
        if (w >= 0) r[w] = 1'b1;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            m_ptr[u] = 0;
            m_vld[u] = 1'b0;
            m_dat[u] = '0;
            m_sel[u] = 0;
            m_win[u] = -1;
            m_ld[u]  = 1'b1;
        end
    endtask

    // Apply inputs, let them settle, and check the combinational grant.
    task automatic drive(input logic [3:0] v, input logic [127:0] d, input logic ordy);
        bus_rr.in_valid  = v;
        bus_fp.in_valid  = v;
        bus_rr.in_data   = d;
        bus_fp.in_data   = d;
        bus_rr.out_ready = ordy;
        bus_fp.out_ready = ordy;
        cur_d = d;
        #2;
        for (int u = 0; u < 2; u++) begin
            m_ld[u]  = !m_vld[u] || ordy;
            m_win[u] = m_ld[u] ? pick(v, (u == 0) ? m_ptr[u] : 0) : -1;
        end
        chk("in_ready_rr", {28'b0, bus_rr.in_ready}, {28'b0, onehot(m_win[0])});
        chk("in_ready_fp", {28'b0, bus_fp.in_ready}, {28'b0, onehot(m_win[1])});
    endtask

    // Take one rising edge, advance the model, and check the registered outputs.
    task automatic clock_check();
        @(posedge clk);
        for (int u = 0; u < 2; u++) begin
            if (m_ld[u]) begin
                if (m_win[u] >= 0) begin
                    m_vld[u] = 1'b1;
                    m_dat[u] = cur_d[m_win[u]*32 +: 32];
                    m_sel[u] = m_win[u];
                    if (u == 0) m_ptr[u] = (m_win[u] + 1) % N;
                end else begin
                    m_vld[u] = 1'b0;
                end
            end
        end
        #1;
        chk("out_valid_rr", {31'b0, bus_rr.out_valid}, {31'b0, m_vld[0]});
        chk("out_valid_fp", {31'b0, bus_fp.out_valid}, {31'b0, m_vld[1]});
        if (m_vld[0]) begin
            chk("out_data_rr", bus_rr.out_data, m_dat[0]);
            chk("out_sel_rr", {30'b0, bus_rr.out_sel}, 32'(m_sel[0]));
        end
        if (m_vld[1]) begin
            chk("out_data_fp", bus_fp.out_data, m_dat[1]);
            chk("out_sel_fp", {30'b0, bus_fp.out_sel}, 32'(m_sel[1]));
        end
    endtask

    initial begin
        logic [127:0] dvec;
        dvec = {32'h3333_4444, 32'hDEAD_BEEF, 32'h1111_2222, 32'hC0DE_0000};

        // Directed table, starting from reset with an empty register and pointer 0.
        tbl.push_back('{4'b0100, 1'b1, 4'b0100, 4'b0100, 1'b1, 2, 2});
        tbl.push_back('{4'b1000, 1'b1, 4'b1000, 4'b1000, 1'b1, 3, 3});
        for (int r = 0; r < 8; r++) begin
            tbl.push_back('{4'b1111, 1'b1, onehot(r % 4), 4'b0001, 1'b1, r % 4, 0});
        end
        for (int r = 0; r < 3; r++) begin
            tbl.push_back('{4'b1010, 1'b0, 4'b0000, 4'b0000, 1'b1, 3, 0});
        end
        tbl.push_back('{4'b1010, 1'b1, 4'b0010, 4'b0010, 1'b1, 1, 1});
        tbl.push_back('{4'b1010, 1'b1, 4'b1000, 4'b0010, 1'b1, 3, 1});
        tbl.push_back('{4'b1010, 1'b1, 4'b0010, 4'b0010, 1'b1, 1, 1});
        tbl.push_back('{4'b1010, 1'b1, 4'b1000, 4'b0010, 1'b1, 3, 1});
        tbl.push_back('{4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 0, 0});
        tbl.push_back('{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 0, 0});
        tbl.push_back('{4'b0001, 1'b0, 4'b0001, 4'b0001, 1'b1, 0, 0});
        tbl.push_back('{4'b0110, 1'b0, 4'b0000, 4'b0000, 1'b1, 0, 0});
        tbl.push_back('{4'b0110, 1'b1, 4'b0010, 4'b0010, 1'b1, 1, 1});
        tbl.push_back('{4'b0001, 1'b1, 4'b0001, 4'b0001, 1'b1, 0, 0});

        // Reset and idle.
        bus_rr.in_valid = '0; bus_fp.in_valid = '0;
        bus_rr.in_data  = '0; bus_fp.in_data  = '0;
        bus_rr.out_ready = 1'b1; bus_fp.out_ready = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", {31'b0, bus_rr.out_valid}, 32'd0);
        resetn = 1'b1;
        for (int c = 0; c < 5; c++) begin
            drive(4'b0000, dvec, 1'b1);
            clock_check();
            chk("idle_data_rr", bus_rr.out_data, 32'd0);
            chk("idle_sel_rr", {30'b0, bus_rr.out_sel}, 32'd0);
            chk("idle_data_fp", bus_fp.out_data, 32'd0);
            chk("idle_sel_fp", {30'b0, bus_fp.out_sel}, 32'd0);
        end

        // Table-driven directed vectors.
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].v, dvec, tbl[i].ordy);
            chk($sformatf("tbl%0d_rdy_rr", i), {28'b0, bus_rr.in_ready}, {28'b0, tbl[i].rdy_rr});
            chk($sformatf("tbl%0d_rdy_fp", i), {28'b0, bus_fp.in_ready}, {28'b0, tbl[i].rdy_fp});
            clock_check();
            chk($sformatf("tbl%0d_vld", i), {31'b0, bus_rr.out_valid}, {31'b0, tbl[i].vld});
            if (tbl[i].vld) begin
                chk($sformatf("tbl%0d_sel_rr", i), {30'b0, bus_rr.out_sel}, 32'(tbl[i].sel_rr));
                chk($sformatf("tbl%0d_sel_fp", i), {30'b0, bus_fp.out_sel}, 32'(tbl[i].sel_fp));
                chk($sformatf("tbl%0d_data_rr", i), bus_rr.out_data, dvec[tbl[i].sel_rr*32 +: 32]);
            end
        end

        // Random traffic against the reference model.
        for (int c = 0; c < 400; c++) begin
            logic [127:0] rd;
            rd = {$urandom, $urandom, $urandom, $urandom};
            drive(4'($urandom_range(0, 15)), rd, $urandom_range(0, 3) != 0);
            clock_check();
        end

        // Async reset mid-stream: leave the pointer at 2, then drop reset between edges.
        drive(4'b0010, dvec, 1'b1);
        clock_check();
        drive(4'b1111, dvec, 1'b1);
        #1;
        resetn = 1'b0;
        #1;
        chk("arst_out_valid_rr", {31'b0, bus_rr.out_valid}, 32'd0);
        chk("arst_out_valid_fp", {31'b0, bus_fp.out_valid}, 32'd0);
        chk("arst_in_ready_rr", {28'b0, bus_rr.in_ready}, 32'h1);
        repeat (2) @(posedge clk);
        #1;
        chk("arst_hold_valid", {31'b0, bus_rr.out_valid}, 32'd0);
        model_reset();
        resetn = 1'b1;
        drive(4'b1111, dvec, 1'b1);
        clock_check();
        chk("arst_restart_sel", {30'b0, bus_rr.out_sel}, 32'd0);
        drive(4'b1111, dvec, 1'b1);
        clock_check();
        chk("arst_next_sel", {30'b0, bus_rr.out_sel}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
